// File: rtl/issue_queue_collapse_if.sv
// Bundle of insert/issue/window signals for issue_queue_collapse.
// master: the upstream stage driving inserts, issue flags and shift amounts.
// slave : the queue itself.
interface issue_queue_collapse_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [2:0]        iss;
  logic [2:0]        sh_e0;
  logic [2:0]        sh_e1;
  logic [2:0]        sh_e2;
  logic [2:0]        sh_rest;
  logic [2:0]        win_valid;
  logic [DATA_W-1:0] win_data0;
  logic [DATA_W-1:0] win_data1;
  logic [DATA_W-1:0] win_data2;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              shift_err;

  modport master (
    output in_valid, in_data, iss, sh_e0, sh_e1, sh_e2, sh_rest,
    input  in_ready, win_valid, win_data0, win_data1, win_data2,
           count, full, empty, shift_err
  );

  modport slave (
    input  in_valid, in_data, iss, sh_e0, sh_e1, sh_e2, sh_rest,
    output in_ready, win_valid, win_data0, win_data1, win_data2,
           count, full, empty, shift_err
  );
endinterface

// File: rtl/issue_queue_collapse.sv
// Collapsing issue queue: entries stay compacted with the oldest at index 0.
// Entries 0..2 form the issue window; issued entries are removed and the
// survivors slide down by externally supplied shift amounts while a new
// entry may be appended above them in the same cycle.
// Optional feature: define IQ_SHIFT_CHECK_EN to build the sticky
// shift-consistency checker driving shift_err (otherwise shift_err = 0).
module issue_queue_collapse #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  flush,
  issue_queue_collapse_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [2:0]        sh [DEPTH];

  logic [2:0]        eff;
  logic [DEPTH-1:0]  eff_ext;
  logic [DEPTH-1:0]  survive;
  logic [CW-1:0]     pop;
  logic [CW-1:0]     ins_idx;
  logic              accept;
  logic              full;

  assign full    = (count_q == CW'(DEPTH));
  // Issue flags on empty window slots are ignored.
  assign eff     = bus.iss & valid_q[2:0];
  assign eff_ext = {{(DEPTH-3){1'b0}}, eff};
  assign survive = valid_q & ~eff_ext;
  assign pop     = CW'(eff[0]) + CW'(eff[1]) + CW'(eff[2]);
  // Space is judged on registered occupancy only, so an issue this cycle
  // never frees room for an insert in the same cycle.
  assign accept  = bus.in_valid && !full;
  // New entry lands directly above the compacted survivors.
  assign ins_idx = count_q - pop;

  // Per-entry shift amount: dedicated inputs for the window, shared for the rest.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sh
    if (gi == 0) begin : g_e0
      assign sh[gi] = bus.sh_e0;
    end else if (gi == 1) begin : g_e1
      assign sh[gi] = bus.sh_e1;
    end else if (gi == 2) begin : g_e2
      assign sh[gi] = bus.sh_e2;
    end else begin : g_rest
      assign sh[gi] = bus.sh_rest;
    end
  end

  // Occupancy update; flush overrides issue and insert.
  always_comb begin
    count_d = count_q - pop + CW'(accept);
    if (flush) begin
      count_d = '0;
    end
  end

  // Valid bits follow the compacted occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign valid_d[gi] = (CW'(gi) < count_d);
  end

  // Payload movement: each slot takes the survivor that shifts onto it, or the insert.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      data_d[j] = data_q[j];
      for (int i = j; i < DEPTH; i++) begin
        if (survive[i] && (int'(sh[i]) == (i - j))) begin
          data_d[j] = data_q[i];
        end
      end
      if (accept && (ins_idx == CW'(j))) begin
        data_d[j] = bus.in_data;
      end
    end
  end

  // Architectural state: valid bits and occupancy, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; contents of invalid slots are don't-care.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      data_q[j] <= data_d[j];
    end
  end

`ifdef IQ_SHIFT_CHECK_EN
  logic       shift_err_q;
  logic       shift_err_d;
  logic       mismatch;
  logic [2:0] below;

  // Each survivor must shift by the number of issued entries beneath it.
  always_comb begin
    mismatch = 1'b0;
    below    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (survive[i] && (sh[i] != below)) begin
        mismatch = 1'b1;
      end
      below = below + {2'b00, eff_ext[i]};
    end
    shift_err_d = flush ? 1'b0 : (shift_err_q | mismatch);
  end

  // Sticky error flag, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_err_q <= 1'b0;
    end else begin
      shift_err_q <= shift_err_d;
    end
  end

  assign bus.shift_err = shift_err_q;
`else
  assign bus.shift_err = 1'b0;
`endif

  assign bus.in_ready  = !full;
  assign bus.full      = full;
  assign bus.empty     = (count_q == '0);
  assign bus.count     = count_q;
  assign bus.win_valid = valid_q[2:0];
  assign bus.win_data0 = data_q[0];
  assign bus.win_data1 = data_q[1];
  assign bus.win_data2 = data_q[2];
endmodule

// File: doc/issue_queue_collapse.md
ISSUE_QUEUE_COLLAPSE -- requirements
Module: issue_queue_collapse

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (range 4..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-006 SHALL have port in_valid  input  1  insert request.
REQ-007 SHALL have port in_data  input  DATA_W  insert payload.
REQ-008 SHALL have port in_ready  output  1  insert accepted when in_valid && in_ready.
REQ-009 SHALL have port iss  input  3  issue flags for entries 0,1,2 (bit0 = entry 0 = oldest).
REQ-010 SHALL have ports sh_e0, sh_e1, sh_e2, sh_rest  input  3 each  shift amounts from the upstream shift-amount stage, applied to entry 0, 1, 2 and entries 3..DEPTH-1.
REQ-011 SHALL have ports win_valid  output  3  and win_data0/1/2  output  DATA_W each  contents of issue window (entries 0..2).
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  occupancy.
REQ-013 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.
REQ-014 SHALL have port shift_err  output  1  sticky shift-consistency error (see Configuration).

Function
REQ-015 Entries SHALL be held compacted: entries 0..count-1 valid, oldest at index 0, none valid above count-1.
REQ-016 Effective issue mask SHALL be eff = iss & valid[2:0]; iss bits on invalid entries are ignored.
REQ-017 Each cycle, issued entries SHALL be removed; each surviving valid entry i SHALL move to index i - sh(i), sh(i) = sh_e0/sh_e1/sh_e2 for i=0/1/2, sh_rest for i>=3.
REQ-018 Shift inputs for entries removed by issue SHALL be ignored.
REQ-019 in_ready SHALL equal !full (registered occupancy only; same-cycle issue does not free space for insertion).
REQ-020 On accepted insert, in_data SHALL be written at index count - popcount(eff), i.e. directly above the compacted survivors.
REQ-021 count_next SHALL equal count - popcount(eff) + (in_valid && in_ready); no wrap below 0 or above DEPTH.
REQ-022 Simultaneous issue and insert SHALL both take effect in the same cycle.
REQ-023 win_valid/win_data SHALL be driven directly from entry registers 0..2; a newly inserted entry landing in 0..2 SHALL appear one cycle after acceptance.
REQ-024 flush SHALL have priority over issue and insert: all valid bits cleared, count=0, insert that cycle dropped.
REQ-025 Payload registers of invalid entries SHALL be don't-care; only valid bits and count are architectural.
REQ-026 The upstream stage SHALL supply shifts equal to popcount(eff below i); behaviour for inconsistent shifts is undefined except for shift_err.

Reset
REQ-027 On rst_n low, asynchronously: all valid bits 0, count=0, empty=1, full=0, in_ready=1, win_valid=0, shift_err=0.
REQ-028 Reset mid-operation SHALL discard all entries with no partial shift committed.
REQ-029 Payload registers SHALL NOT require reset.

Configuration
REQ-030 Macro IQ_SHIFT_CHECK_EN defined: each cycle, for every surviving valid entry, compare sh(i) with popcount(eff bits below i); any mismatch sets shift_err on next edge, held until reset or flush.
REQ-031 Macro IQ_SHIFT_CHECK_EN undefined: checker logic absent, shift_err tied 0; queue function identical.

Verification
REQ-032 Reset, insert A,B,C,D on four cycles -> count=4, win_data0/1/2=A,B,C, win_valid=3'b111, empty=0.
REQ-033 Queue A..E, iss=3'b010, sh_e0=0, sh_e2=1, sh_rest=1 -> next cycle entries A,C,D,E, count=4, shift_err=0.
REQ-034 Full queue (count=8), in_valid=1, iss=3'b001, shifts 1 -> insert refused (in_ready=0), count=7, following cycle in_ready=1.
REQ-035 Queue A,B,C, iss=3'b101, in_valid=1 with X, shifts sh_e1=1 -> entries B,X, count=2.
REQ-036 With IQ_SHIFT_CHECK_EN, queue A..E, iss=3'b001, sh_rest=2 -> shift_err=1 next cycle, stays 1 until flush; flush -> count=0, shift_err=0.
